csi_frame_monitor: RTL and testbench

Non-intrusive stream monitor in the `csi_byte_clk` domain, directly downstream of `csi_rx_top`, alongside `isp_top`. It taps the unpacked word-valid, line and frame flags and measures words per line, lines per frame and frame count. It checks them against the configured geometry, keeps saturating error counters and raises a `locked` status for LEDs and debug pins. It never back-pressures or modifies the video path.

---
 rtl/csi_frame_monitor.sv | 272 +++++++++++++++++++++++++++
 tb/tb_csi_frame_monitor.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_frame_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csi_frame_monitor                                               |
// | Purpose  : Passive CSI stream geometry monitor: words/line, lines/frame,   |
// |            frame count, saturating error counters and a lock indication.   |
// |            Optional FPS measurement is built when CSI_MON_FPS_EN is set.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module csi_frame_monitor #(
    parameter int LINE_LENGTH     = 640,
    parameter int LINES_PER_FRAME = 480,
    parameter int CNT_W           = 16,
    parameter int CLK_HZ          = 100_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             csi_word_valid,
    input  logic             csi_in_line,
    input  logic             csi_in_frame,
    input  logic             clear,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       err_line,
    output logic [7:0]       err_frame,
    output logic [7:0]       err_orphan,
    output logic             stat_valid,
    output logic             locked,
    output logic [7:0]       fps,
    output logic             fps_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ORPHAN = 2'd1,
        S_FRAME  = 2'd2,
        S_LINE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_line_length     = CNT_W'(LINE_LENGTH);
    localparam logic [CNT_W-1:0] c_lines_per_frame = CNT_W'(LINES_PER_FRAME);
    localparam logic [CNT_W-1:0] c_cnt_max         = {CNT_W{1'b1}};
    localparam logic [7:0]       c_err_max         = 8'hFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_line_d;
    logic             r_frame_d;
    logic             r_armed;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_line_num;
    logic             r_frame_bad;
    logic             r_good_once;

    logic w_line_rise;
    logic w_line_fall;
    logic w_frame_rise;
    logic w_frame_fall;
    logic w_frame_start;
    logic w_line_start;
    logic w_word_inc;
    logic w_line_close;
    logic w_line_trunc;
    logic w_frame_close;
    logic w_orphan;
    logic w_line_err;
    logic w_frame_err;
    logic w_any_err;

    assign w_line_rise  =  csi_in_line  & ~r_line_d;
    assign w_line_fall  = ~csi_in_line  &  r_line_d;
    assign w_frame_rise =  csi_in_frame & ~r_frame_d;
    assign w_frame_fall = ~csi_in_frame &  r_frame_d;

    assign w_line_err  = (w_line_close && (r_word_cnt != c_line_length)) || w_line_trunc;
    assign w_frame_err = w_frame_close &&
                         ((r_line_num != c_lines_per_frame) || r_frame_bad || w_line_err);
    assign w_any_err   = w_line_err | w_frame_err | w_orphan;

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_line_start  = 1'b0;
        w_word_inc    = 1'b0;
        w_line_close  = 1'b0;
        w_line_trunc  = 1'b0;
        w_frame_close = 1'b0;
        w_orphan      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Until a frame-low sample is seen after reset, a frame that was
                // already running is not ours to measure.
                if (r_armed) begin
                    if (w_frame_rise) begin
                        w_frame_start = 1'b1;
                        w_state_nxt   = S_FRAME;
                        if (w_line_rise) begin
                            w_line_start = 1'b1;
                            w_state_nxt  = S_LINE;
                        end
                    end else if (w_line_rise) begin
                        w_orphan    = 1'b1;
                        w_state_nxt = S_ORPHAN;
                    end
                end
            end
            S_ORPHAN: begin
                if (w_line_fall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FRAME: begin
                if (w_frame_fall) begin
                    w_frame_close = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (w_line_rise) begin
                    w_line_start = 1'b1;
                    w_state_nxt  = S_LINE;
                end
            end
            S_LINE: begin
                if (w_line_fall) begin
                    w_line_close = 1'b1;
                    w_state_nxt  = S_FRAME;
                    if (w_frame_fall) begin
                        w_frame_close = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end else if (w_frame_fall) begin
                    w_line_trunc  = 1'b1;
                    w_frame_close = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (csi_in_line && csi_word_valid) begin
                    w_word_inc = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tracking state of the stream; untouched by clear except the frame-error memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_line_d    <= 1'b0;
            r_frame_d   <= 1'b0;
            r_armed     <= 1'b0;
            r_word_cnt  <= '0;
            r_line_num  <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_line_d  <= csi_in_line;
            r_frame_d <= csi_in_frame;
            r_armed   <= r_armed | ~csi_in_frame;

            if (w_line_start) begin
                r_word_cnt <= CNT_W'(csi_word_valid);
            end else if (w_word_inc && (r_word_cnt != c_cnt_max)) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end

            if (w_frame_start) begin
                r_line_num <= CNT_W'(w_line_start);
            end else if (w_line_start && (r_line_num != c_cnt_max)) begin
                r_line_num <= r_line_num + CNT_W'(1);
            end

            if (clear || w_frame_start) begin
                r_frame_bad <= 1'b0;
            end else if (w_line_err) begin
                r_frame_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_len    <= '0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
            err_line    <= '0;
            err_frame   <= '0;
            err_orphan  <= '0;
            stat_valid  <= 1'b0;
            locked      <= 1'b0;
            r_good_once <= 1'b0;
        end else if (clear) begin
            line_len    <= '0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
            err_line    <= '0;
            err_frame   <= '0;
            err_orphan  <= '0;
            stat_valid  <= 1'b0;
            locked      <= 1'b0;
            r_good_once <= 1'b0;
        end else begin
            stat_valid <= w_frame_close;

            if (w_line_close) begin
                line_len <= r_word_cnt;
            end
            if (w_line_err && (err_line != c_err_max)) begin
                err_line <= err_line + 8'd1;
            end
            if (w_frame_err && (err_frame != c_err_max)) begin
                err_frame <= err_frame + 8'd1;
            end
            if (w_orphan && (err_orphan != c_err_max)) begin
                err_orphan <= err_orphan + 8'd1;
            end

            if (w_frame_close) begin
                line_cnt  <= r_line_num;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            // Lock needs two clean frame closes in a row; any error restarts the history.
            if (w_any_err) begin
                r_good_once <= 1'b0;
                locked      <= 1'b0;
            end else if (w_frame_close) begin
                r_good_once <= 1'b1;
                if (r_good_once) begin
                    locked <= 1'b1;
                end
            end
        end
    end

`ifdef CSI_MON_FPS_EN
    localparam int               c_tb_w    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_tb_w-1:0] c_tb_last = c_tb_w'(CLK_HZ - 1);

    logic [c_tb_w-1:0] r_timebase;
    logic [7:0]        r_fps_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timebase <= '0;
            r_fps_acc  <= '0;
            fps        <= '0;
            fps_valid  <= 1'b0;
        end else if (clear) begin
            r_timebase <= '0;
            r_fps_acc  <= '0;
            fps        <= '0;
            fps_valid  <= 1'b0;
        end else if (r_timebase == c_tb_last) begin
            // A close landing on the wrap belongs to the interval just starting.
            r_timebase <= '0;
            fps        <= r_fps_acc;
            fps_valid  <= 1'b1;
            r_fps_acc  <= {7'd0, w_frame_close};
        end else begin
            r_timebase <= r_timebase + c_tb_w'(1);
            fps_valid  <= 1'b0;
            if (w_frame_close && (r_fps_acc != c_err_max)) begin
                r_fps_acc <= r_fps_acc + 8'd1;
            end
        end
    end
`else
    logic w_unused_clk_hz;
    assign w_unused_clk_hz = (CLK_HZ > 0);
    assign fps             = '0;
    assign fps_valid       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csi_frame_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_csi_frame_monitor                                            |
// | Purpose  : Randomised self-checking bench for csi_frame_monitor against a   |
// |            frame-level reference model. FPS checks need CSI_MON_FPS_EN.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_csi_frame_monitor;

    localparam int LL  = 16;
    localparam int LPF = 8;
    localparam int CW  = 16;
    localparam int HZ  = 1000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid = 1'b0;
    logic          in_line = 1'b0;
    logic          in_frame = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] line_len, line_cnt, frame_cnt;
    logic [7:0]    err_line, err_frame, err_orphan, fps;
    logic          stat_valid, locked, fps_valid;

    always #5 clk = ~clk;

    csi_frame_monitor #(
        .LINE_LENGTH    (LL),
        .LINES_PER_FRAME(LPF),
        .CNT_W          (CW),
        .CLK_HZ         (HZ)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .csi_word_valid(valid),
        .csi_in_line   (in_line),
        .csi_in_frame  (in_frame),
        .clear         (clr),
        .line_len      (line_len),
        .line_cnt      (line_cnt),
        .frame_cnt     (frame_cnt),
        .err_line      (err_line),
        .err_frame     (err_frame),
        .err_orphan    (err_orphan),
        .stat_valid    (stat_valid),
        .locked        (locked),
        .fps           (fps),
        .fps_valid     (fps_valid)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model state, advanced per completed line / frame.
    int m_line_len, m_line_cnt, m_frame_cnt, m_err_line, m_err_frame, m_err_orphan;
    bit m_good, m_locked, m_fbad;

    int sv_cnt = 0;
    int fv_cnt = 0;
    int cyc_cnt = 0;
    int fv_last_cyc = 0;
    logic [7:0] fv_last_fps = '0;

    always @(posedge clk) cyc_cnt <= reset_n ? cyc_cnt + 1 : 0;

    always @(negedge clk) begin
        if (stat_valid) sv_cnt++;
        if (fps_valid) begin
            fv_cnt++;
            fv_last_cyc = cyc_cnt;
            fv_last_fps = fps;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int sat8(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic void m_reset();
        m_line_len = 0; m_line_cnt = 0; m_frame_cnt = 0;
        m_err_line = 0; m_err_frame = 0; m_err_orphan = 0;
        m_good = 0; m_locked = 0; m_fbad = 0;
    endfunction

    function automatic void m_error();
        m_good = 0;
        m_locked = 0;
    endfunction

    function automatic void m_line_done(input int len);
        m_line_len = len;
        if (len != LL) begin
            m_err_line = sat8(m_err_line);
            m_fbad = 1;
            m_error();
        end
    endfunction

    function automatic void m_trunc();
        m_err_line = sat8(m_err_line);
        m_fbad = 1;
        m_error();
    endfunction

    function automatic void m_orphan();
        m_err_orphan = sat8(m_err_orphan);
        m_error();
    endfunction

    function automatic void m_frame_done(input int nl);
        m_line_cnt  = nl;
        m_frame_cnt = (m_frame_cnt + 1) % 65536;
        if (nl != LPF || m_fbad) begin
            m_err_frame = sat8(m_err_frame);
            m_error();
        end else begin
            if (m_good) m_locked = 1;
            m_good = 1;
        end
        m_fbad = 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One line of n valid words with random bubbles; optional frame fall / clear on its fall.
    task automatic send_line(input int n, input bit end_frame, input bit do_clear);
        int w;
        w = 0;
        in_line = 1'b1;
        do begin
            valid = (w < n) && ($urandom_range(3, 0) != 0);
            if (valid) w++;
            cyc();
        end while (w < n);
        in_line = 1'b0;
        valid = 1'($urandom_range(1, 0));
        if (end_frame) in_frame = 1'b0;
        clr = do_clear;
        cyc();
        clr = 1'b0;
        valid = 1'b0;
        repeat ($urandom_range(2, 1)) cyc();
    endtask

    task automatic send_frame(input int nl, input int bad_idx, input int bad_len, input int chk_idx);
        int len;
        bit coinc;
        coinc = 0;
        in_frame = 1'b1;
        if ($urandom_range(1, 0) == 1) cyc();
        for (int i = 0; i < nl; i++) begin
            len = (i == bad_idx) ? bad_len : LL;
            coinc = (i == nl - 1) && ($urandom_range(1, 0) == 1);
            send_line(len, coinc, 1'b0);
            m_line_done(len);
            if (i == chk_idx) begin
                n_total++;
                if (line_len !== CW'(m_line_len)) $display("FAIL mid_line_len: got %0d required %0d", line_len, m_line_len); else n_pass++;
                n_total++;
                if (err_line !== 8'(m_err_line)) $display("FAIL mid_err_line: got %0d required %0d", err_line, m_err_line); else n_pass++;
                n_total++;
                if (locked !== m_locked) $display("FAIL mid_locked: got %0b required %0b", locked, m_locked); else n_pass++;
            end
        end
        if (!coinc) begin
            in_frame = 1'b0;
            cyc();
        end
        repeat (2) cyc();
        m_frame_done(nl);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cyc();
        n_total++;
        if ({line_len, line_cnt, frame_cnt, err_line, err_frame, err_orphan, stat_valid, locked, fps, fps_valid} !== '0)
            $display("FAIL reset_in: got nonzero outputs (line_len %0d frame_cnt %0d), required all 0", line_len, frame_cnt);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) cyc();
        m_reset();
        n_total++;
        if ({line_len, line_cnt, frame_cnt, err_line, err_frame, err_orphan, stat_valid, locked} !== '0)
            $display("FAIL reset_out: got nonzero outputs (locked %0b), required all 0", locked);
        else n_pass++;
    endtask

    task automatic test_good_frames();
        int sv0;
        sv0 = sv_cnt;
        for (int f = 0; f < 3; f++) begin
            send_frame(LPF, -1, LL, -1);
            n_total++;
            if (frame_cnt !== CW'(m_frame_cnt)) $display("FAIL good_frame_cnt: got %0d required %0d", frame_cnt, m_frame_cnt); else n_pass++;
            n_total++;
            if (line_cnt !== CW'(LPF) || line_len !== CW'(LL)) $display("FAIL good_geom: got %0d/%0d required %0d/%0d", line_cnt, line_len, LPF, LL); else n_pass++;
            n_total++;
            if (locked !== m_locked) $display("FAIL good_locked: got %0b required %0b", locked, m_locked); else n_pass++;
        end
        n_total++;
        if ({err_line, err_frame, err_orphan} !== '0) $display("FAIL good_errs: got %0d %0d %0d required 0 0 0", err_line, err_frame, err_orphan); else n_pass++;
        n_total++;
        if (sv_cnt - sv0 !== 3) $display("FAIL good_stat_pulses: got %0d required 3", sv_cnt - sv0); else n_pass++;
    endtask

    task automatic test_bad_line();
        send_frame(LPF, 2, LL - 1, 2);
        n_total++;
        if (err_frame !== 8'(m_err_frame) || err_line !== 8'(m_err_line)) $display("FAIL badline_errs: got %0d/%0d required %0d/%0d", err_line, err_frame, m_err_line, m_err_frame); else n_pass++;
        n_total++;
        if (locked !== 1'b0) $display("FAIL badline_locked: got %0b required 0", locked); else n_pass++;
        send_frame(LPF, -1, LL, -1);
        n_total++;
        if (locked !== 1'b0) $display("FAIL relock_early: got %0b required 0", locked); else n_pass++;
        send_frame(LPF, -1, LL, -1);
        n_total++;
        if (locked !== 1'b1) $display("FAIL relock: got %0b required 1", locked); else n_pass++;
    endtask

    task automatic test_short_orphan();
        send_frame(LPF - 1, -1, LL, -1);
        n_total++;
        if (line_cnt !== CW'(LPF - 1) || err_frame !== 8'(m_err_frame)) $display("FAIL short_frame: got cnt %0d err %0d required %0d %0d", line_cnt, err_frame, LPF - 1, m_err_frame); else n_pass++;
        send_line(5, 1'b0, 1'b0);
        m_orphan();
        n_total++;
        if (err_orphan !== 8'(m_err_orphan)) $display("FAIL orphan_cnt: got %0d required %0d", err_orphan, m_err_orphan); else n_pass++;
        n_total++;
        if (line_len !== CW'(m_line_len)) $display("FAIL orphan_line_len: got %0d required %0d", line_len, m_line_len); else n_pass++;
    endtask

    task automatic test_truncated();
        int sv0;
        int w;
        sv0 = sv_cnt;
        in_frame = 1'b1;
        cyc();
        send_line(LL, 1'b0, 1'b0);
        m_line_done(LL);
        in_line = 1'b1;
        w = 0;
        while (w < 10) begin
            valid = 1'($urandom_range(1, 0));
            if (valid) w++;
            cyc();
        end
        in_frame = 1'b0;
        cyc();
        valid = 1'b0;
        repeat (2) cyc();
        in_line = 1'b0;
        repeat (2) cyc();
        m_trunc();
        m_frame_done(2);
        n_total++;
        if (err_line !== 8'(m_err_line) || err_frame !== 8'(m_err_frame)) $display("FAIL trunc_errs: got %0d/%0d required %0d/%0d", err_line, err_frame, m_err_line, m_err_frame); else n_pass++;
        n_total++;
        if (line_len !== CW'(m_line_len) || line_cnt !== CW'(2)) $display("FAIL trunc_geom: got %0d/%0d required %0d/2", line_len, line_cnt, m_line_len); else n_pass++;
        n_total++;
        if (sv_cnt - sv0 !== 1 || frame_cnt !== CW'(m_frame_cnt)) $display("FAIL trunc_close: got pulses %0d frames %0d required 1 %0d", sv_cnt - sv0, frame_cnt, m_frame_cnt); else n_pass++;
        send_frame(LPF, -1, LL, -1);
        n_total++;
        if (frame_cnt !== CW'(m_frame_cnt) || line_cnt !== CW'(LPF)) $display("FAIL trunc_resume: got %0d/%0d required %0d/%0d", frame_cnt, line_cnt, m_frame_cnt, LPF); else n_pass++;
    endtask

    task automatic test_clear();
        in_frame = 1'b1;
        cyc();
        send_line(LL, 1'b0, 1'b0);
        send_line(LL + 3, 1'b0, 1'b1);
        n_total++;
        if ({line_len, line_cnt, frame_cnt, err_line, err_frame, err_orphan, stat_valid, locked, fps, fps_valid} !== '0)
            $display("FAIL clear_zero: got err_line %0d line_len %0d frame_cnt %0d required 0", err_line, line_len, frame_cnt);
        else n_pass++;
        in_frame = 1'b0;
        repeat (2) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        m_reset();
        send_frame(LPF, -1, LL, -1);
        n_total++;
        if (frame_cnt !== CW'(1) || line_cnt !== CW'(LPF) || line_len !== CW'(LL)) $display("FAIL clear_resume: got %0d/%0d/%0d required 1/%0d/%0d", frame_cnt, line_cnt, line_len, LPF, LL); else n_pass++;
        n_total++;
        if ({err_line, err_frame, err_orphan} !== '0) $display("FAIL clear_errs: got %0d %0d %0d required 0", err_line, err_frame, err_orphan); else n_pass++;
    endtask

    task automatic test_reset_midline();
        int sv0;
        in_frame = 1'b1;
        cyc();
        in_line = 1'b1;
        valid = 1'b1;
        repeat (5) cyc();
        reset_n = 1'b0;
        repeat (2) cyc();
        n_total++;
        if ({line_len, line_cnt, frame_cnt, err_line, err_frame, err_orphan, stat_valid, locked, fps, fps_valid} !== '0)
            $display("FAIL rst_mid_zero: got frame_cnt %0d err_line %0d required 0", frame_cnt, err_line);
        else n_pass++;
        reset_n = 1'b1;
        m_reset();
        sv0 = sv_cnt;
        repeat (3) cyc();
        in_line = 1'b0;
        cyc();
        in_line = 1'b1;
        repeat (4) cyc();
        in_line = 1'b0;
        valid = 1'b0;
        cyc();
        in_frame = 1'b0;
        repeat (2) cyc();
        n_total++;
        if (frame_cnt !== '0 || err_orphan !== '0 || sv_cnt != sv0) $display("FAIL rst_ignore: got frames %0d orphans %0d pulses %0d required 0", frame_cnt, err_orphan, sv_cnt - sv0); else n_pass++;
        send_frame(LPF, -1, LL, -1);
        n_total++;
        if (frame_cnt !== CW'(1) || line_cnt !== CW'(LPF) || err_line !== '0) $display("FAIL rst_resume: got %0d/%0d/%0d required 1/%0d/0", frame_cnt, line_cnt, err_line, LPF); else n_pass++;
    endtask

    task automatic test_random();
        int nl, r, bi, bl;
        for (int f = 0; f < 8; f++) begin
            nl = LPF; bi = -1; bl = LL;
            r = int'($urandom_range(3, 0));
            if (r == 1) nl = ($urandom_range(1, 0) == 1) ? LPF - 1 : LPF + 1;
            else if (r == 2) begin
                bi = int'($urandom_range(LPF - 1, 0));
                bl = ($urandom_range(1, 0) == 1) ? LL + 1 : LL - int'($urandom_range(3, 1));
            end
            send_frame(nl, bi, bl, -1);
            n_total++;
            if (line_len !== CW'(m_line_len) || line_cnt !== CW'(m_line_cnt) || frame_cnt !== CW'(m_frame_cnt))
                $display("FAIL rnd_geom[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", f, line_len, line_cnt, frame_cnt, m_line_len, m_line_cnt, m_frame_cnt);
            else n_pass++;
            n_total++;
            if (err_line !== 8'(m_err_line) || err_frame !== 8'(m_err_frame) || locked !== m_locked)
                $display("FAIL rnd_errs[%0d]: got %0d/%0d/%0b required %0d/%0d/%0b", f, err_line, err_frame, locked, m_err_line, m_err_frame, m_locked);
            else n_pass++;
            if ($urandom_range(3, 0) == 0) begin
                send_line(int'($urandom_range(5, 0)), 1'b0, 1'b0);
                m_orphan();
                n_total++;
                if (err_orphan !== 8'(m_err_orphan) || line_len !== CW'(m_line_len) || locked !== 1'b0)
                    $display("FAIL rnd_orphan[%0d]: got %0d/%0d/%0b required %0d/%0d/0", f, err_orphan, line_len, locked, m_err_orphan, m_line_len);
                else n_pass++;
            end
        end
    endtask

    task automatic short_frame();
        in_frame = 1'b1; in_line = 1'b1; valid = 1'b1;
        cyc();
        in_frame = 1'b0; in_line = 1'b0; valid = 1'b0;
        cyc();
    endtask

    task automatic test_fps();
`ifdef CSI_MON_FPS_EN
        int guard;
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        fv_cnt = 0;
        repeat (5) short_frame();
        guard = 0;
        while (fv_cnt == 0 && guard < 1500) begin cyc(); guard++; end
        n_total++;
        if (fv_cnt != 1 || fv_last_fps !== 8'd5) $display("FAIL fps_5: got pulses %0d fps %0d required 1 5", fv_cnt, fv_last_fps); else n_pass++;
        n_total++;
        if (fv_last_cyc != HZ) $display("FAIL fps_when: got cycle %0d required %0d", fv_last_cyc, HZ); else n_pass++;
        repeat (300) short_frame();
        guard = 0;
        while (fv_cnt < 2 && guard < 1500) begin cyc(); guard++; end
        n_total++;
        if (fv_cnt != 2 || fv_last_fps !== 8'd255) $display("FAIL fps_sat: got pulses %0d fps %0d required 2 255", fv_cnt, fv_last_fps); else n_pass++;
`else
        n_total++;
        if (fv_cnt != 0 || fps !== 8'd0) $display("FAIL fps_off: got pulses %0d fps %0d required 0 0", fv_cnt, fps); else n_pass++;
`endif
    endtask

    initial begin
        m_reset();
        test_reset();
        test_good_frames();
        test_bad_line();
        test_short_orphan();
        test_truncated();
        test_random();
        test_clear();
        test_reset_midline();
        test_fps();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
